// File: rtl/ccd_ctrl_pkg.sv
// Shared encodings and widths for the CCD capture controller.
package ccd_ctrl_pkg;

    localparam int unsigned TIMEOUT_CYC_DEF = 5_000_000;
    localparam int unsigned FRAME_W         = 16;
    localparam int unsigned ERR_W           = 8;
    localparam int unsigned STATE_W         = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_STOP    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    // States in which a capture session is in progress and the watchdog runs.
    function automatic logic is_busy(state_t s);
        return (s == ST_ARM) || (s == ST_CAPTURE) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/ccd_fval_edge.sv
// Registers the sensor frame-valid and flags its rising and falling edges.
module ccd_fval_edge (
    input  logic clk,
    input  logic rst,
    input  logic fval,
    output logic rise_c,
    output logic fall_c
);

    logic fval_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fval_d <= 1'b0;
        end else begin
            fval_d <= fval;
        end
    end

    assign rise_c = fval & ~fval_d;
    assign fall_c = ~fval & fval_d;

endmodule

// File: rtl/ccd_capture_ctrl.sv
// CCD capture sequencer: continuous or burst capture gated on frame boundaries,
// with a frame-valid watchdog and a saturating capture-error counter.
module ccd_capture_ctrl
    import ccd_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned NUM_W       = 8
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iRUN,
    input  logic               iSNAP,
    input  logic [NUM_W-1:0]   iNUM_FRAMES,
    input  logic               iABORT,
    input  logic               iCLR,
    input  logic               iFVAL,
    input  logic               iCAP_ERR,
    output logic               oEND,
    output logic               oBUSY,
    output logic               oDONE,
    output logic               oTIMEOUT,
    output logic [FRAME_W-1:0] oFRAME_CNT,
    output logic [ERR_W-1:0]   oERR_CNT,
    output logic [STATE_W-1:0] oSTATE
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    state_t            next_state;
    logic              single;
    logic [NUM_W-1:0]  target;
    logic [WD_W-1:0]   wd;
    logic              rise;
    logic              fall;
    logic              fval_edge;
    logic              wd_expired;
    logic              last_frame;

    logic              arm_single;
    logic              arm_cont;
    logic              burst_done;
    logic              timeout_hit;
    logic              fault_clr;

    ccd_fval_edge u_fval_edge (
        .clk    (iCLK),
        .rst    (iRST),
        .fval   (iFVAL),
        .rise_c (rise),
        .fall_c (fall)
    );

    assign fval_edge  = rise | fall;
    // An edge in the same cycle restarts the watchdog, so it cannot also expire.
    assign wd_expired = (wd == WD_W'(TIMEOUT_CYC - 1)) && !fval_edge;
    assign last_frame = (oFRAME_CNT == FRAME_W'(target));
    assign oSTATE     = state;

    // Next-state and per-cycle event decode; abort outranks every other event.
    always_comb begin
        next_state  = state;
        arm_single  = 1'b0;
        arm_cont    = 1'b0;
        burst_done  = 1'b0;
        timeout_hit = 1'b0;
        fault_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iSNAP && (iNUM_FRAMES != '0)) begin
                    next_state = ST_ARM;
                    arm_single = 1'b1;
                end else if (iRUN) begin
                    next_state = ST_ARM;
                    arm_cont   = 1'b1;
                end
            end
            ST_ARM: begin
                if (iABORT) begin
                    next_state = ST_IDLE;
                end else if (wd_expired) begin
                    next_state  = ST_FAULT;
                    timeout_hit = 1'b1;
                end else if (!iFVAL) begin
                    next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (iABORT) begin
                    next_state = ST_IDLE;
                end else if (wd_expired) begin
                    next_state  = ST_FAULT;
                    timeout_hit = 1'b1;
                end else if (single && fall && last_frame) begin
                    next_state = ST_IDLE;
                    burst_done = 1'b1;
                end else if (!single && !iRUN) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (iABORT) begin
                    next_state = ST_IDLE;
                end else if (wd_expired) begin
                    next_state  = ST_FAULT;
                    timeout_hit = 1'b1;
                end else if (!iFVAL) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (iCLR) begin
                    next_state = ST_IDLE;
                    fault_clr  = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= ST_IDLE;
            oEND       <= 1'b1;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
            oTIMEOUT   <= 1'b0;
            oFRAME_CNT <= '0;
            single     <= 1'b0;
            target     <= '0;
            wd         <= '0;
        end else begin
            state <= next_state;
            oEND  <= !((next_state == ST_CAPTURE) || (next_state == ST_STOP));
            oBUSY <= is_busy(next_state);
            oDONE <= burst_done;

            if (timeout_hit) begin
                oTIMEOUT <= 1'b1;
            end else if (fault_clr) begin
                oTIMEOUT <= 1'b0;
            end

            if (arm_single || arm_cont) begin
                oFRAME_CNT <= '0;
                single     <= arm_single;
            end else if ((state == ST_CAPTURE) && rise) begin
                oFRAME_CNT <= oFRAME_CNT + FRAME_W'(1);
            end

            if (arm_single) begin
                target <= iNUM_FRAMES;
            end

            if ((next_state != state) || fval_edge || !is_busy(state)) begin
                wd <= '0;
            end else begin
                wd <= wd + WD_W'(1);
            end
        end
    end

    // Error counter saturates; a clear wins over a same-cycle error.
    always_ff @(posedge iCLK) begin
        if (iRST || iCLR) begin
            oERR_CNT <= '0;
        end else if (iCAP_ERR && (oERR_CNT != '1)) begin
            oERR_CNT <= oERR_CNT + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_ccd_capture_ctrl.sv
// Self-checking bench for ccd_capture_ctrl: directed scenarios plus randomized
// bursts, sessions and error streams checked against arithmetic expectations.
module tb_ccd_capture_ctrl;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iRUN = 1'b0;
    logic        iSNAP = 1'b0;
    logic [7:0]  iNUM_FRAMES = '0;
    logic        iABORT = 1'b0;
    logic        iCLR = 1'b0;
    logic        iFVAL = 1'b0;
    logic        iCAP_ERR = 1'b0;

    logic        oEND, oBUSY, oDONE, oTIMEOUT;
    logic [15:0] oFRAME_CNT;
    logic [7:0]  oERR_CNT;
    logic [2:0]  oSTATE;

    logic        w_end, w_busy, w_done, w_timeout;
    logic [15:0] w_frame_cnt;
    logic [7:0]  w_err_cnt;
    logic [2:0]  w_state;

    int errors      = 0;
    int checks      = 0;
    int done_seen   = 0;
    int endlow_seen = 0;

    always #5 iCLK = ~iCLK;

    ccd_capture_ctrl #(.TIMEOUT_CYC(1000), .NUM_W(8)) dut (
        .iCLK(iCLK), .iRST(iRST), .iRUN(iRUN), .iSNAP(iSNAP),
        .iNUM_FRAMES(iNUM_FRAMES), .iABORT(iABORT), .iCLR(iCLR),
        .iFVAL(iFVAL), .iCAP_ERR(iCAP_ERR),
        .oEND(oEND), .oBUSY(oBUSY), .oDONE(oDONE), .oTIMEOUT(oTIMEOUT),
        .oFRAME_CNT(oFRAME_CNT), .oERR_CNT(oERR_CNT), .oSTATE(oSTATE)
    );

    ccd_capture_ctrl #(.TIMEOUT_CYC(50), .NUM_W(8)) dut_wd (
        .iCLK(iCLK), .iRST(iRST), .iRUN(iRUN), .iSNAP(iSNAP),
        .iNUM_FRAMES(iNUM_FRAMES), .iABORT(iABORT), .iCLR(iCLR),
        .iFVAL(iFVAL), .iCAP_ERR(iCAP_ERR),
        .oEND(w_end), .oBUSY(w_busy), .oDONE(w_done), .oTIMEOUT(w_timeout),
        .oFRAME_CNT(w_frame_cnt), .oERR_CNT(w_err_cnt), .oSTATE(w_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge iCLK);
        #1;
        if (oDONE === 1'b1) done_seen++;
        if (oEND === 1'b0) endlow_seen++;
    endtask

    task automatic reset_all();
        iRST = 1'b1; iRUN = 1'b0; iSNAP = 1'b0; iABORT = 1'b0;
        iCLR = 1'b0; iFVAL = 1'b0; iCAP_ERR = 1'b0; iNUM_FRAMES = '0;
        tick();
        tick();
        iRST = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(oSTATE), 0);
        chk({tag, "_end"}, 32'(oEND), 1);
        chk({tag, "_busy"}, 32'(oBUSY), 0);
        chk({tag, "_done"}, 32'(oDONE), 0);
        chk({tag, "_timeout"}, 32'(oTIMEOUT), 0);
        chk({tag, "_frames"}, 32'(oFRAME_CNT), 0);
        chk({tag, "_errs"}, 32'(oERR_CNT), 0);
    endtask

    // Single-shot burst of n frames with frame/gap lengths drawn from the given ranges.
    task automatic run_burst(input string tag, input int n, input int hi_min, input int hi_max,
                             input int lo_min, input int lo_max);
        int hi, lo, exp_low, d0, l0;
        d0 = done_seen;
        l0 = endlow_seen;
        exp_low = 1;
        iNUM_FRAMES = 8'(n);
        iSNAP = 1'b1;
        tick();
        iSNAP = 1'b0;
        chk({tag, "_arm"}, 32'(oSTATE), 1);
        tick();
        chk({tag, "_capture"}, 32'(oSTATE), 2);
        for (int f = 0; f < n; f++) begin
            hi = int'($urandom_range(hi_max, hi_min));
            lo = int'($urandom_range(lo_max, lo_min));
            iFVAL = 1'b1;
            repeat (hi) tick();
            exp_low += hi;
            iFVAL = 1'b0;
            if (f == n - 1) begin
                tick();
                chk({tag, "_done_at_fall"}, 32'(oDONE), 1);
                chk({tag, "_end_at_fall"}, 32'(oEND), 1);
                repeat (lo - 1) tick();
            end else begin
                exp_low += lo;
                repeat (lo) tick();
            end
        end
        chk({tag, "_frames"}, 32'(oFRAME_CNT), 32'(n));
        chk({tag, "_done_count"}, 32'(done_seen - d0), 1);
        chk({tag, "_end_low_cycles"}, 32'(endlow_seen - l0), 32'(exp_low));
        chk({tag, "_idle"}, 32'(oSTATE), 0);
    endtask

    initial begin
        int n, k, hi, lo, d0;

        // Reset values
        reset_all();
        chk_reset_vals("reset");

        // Snap with zero frames is ignored
        iNUM_FRAMES = 8'd0;
        iSNAP = 1'b1;
        tick();
        iSNAP = 1'b0;
        chk("snap_zero_state", 32'(oSTATE), 0);
        chk("snap_zero_busy", 32'(oBUSY), 0);

        // Three 100-cycle frames
        run_burst("burst3", 3, 100, 100, 20, 20);
        chk("burst3_end_after", 32'(oEND), 1);

        // Randomized bursts
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(5, 1));
            run_burst("burst_rand", n, 5, 40, 3, 20);
        end

        // Arm while a frame is in flight, then stop gracefully mid-frame
        reset_all();
        iFVAL = 1'b1;
        tick();
        iRUN = 1'b1;
        tick();
        chk("midarm_state", 32'(oSTATE), 1);
        chk("midarm_end", 32'(oEND), 1);
        repeat (5) tick();
        chk("midarm_hold_state", 32'(oSTATE), 1);
        chk("midarm_hold_end", 32'(oEND), 1);
        iFVAL = 1'b0;
        tick();
        chk("midarm_release_state", 32'(oSTATE), 2);
        chk("midarm_release_end", 32'(oEND), 0);
        chk("midarm_partial_uncounted", 32'(oFRAME_CNT), 0);
        iFVAL = 1'b1;
        repeat (10) tick();
        chk("midarm_first_frame", 32'(oFRAME_CNT), 1);
        d0 = done_seen;
        iRUN = 1'b0;
        tick();
        chk("stop_state", 32'(oSTATE), 3);
        chk("stop_end", 32'(oEND), 0);
        repeat (5) tick();
        chk("stop_hold_end", 32'(oEND), 0);
        iFVAL = 1'b0;
        tick();
        chk("stop_idle_state", 32'(oSTATE), 0);
        chk("stop_idle_end", 32'(oEND), 1);
        chk("stop_no_done", 32'(done_seen - d0), 0);
        chk("stop_frames", 32'(oFRAME_CNT), 1);

        // Randomized continuous sessions, run dropped in an inter-frame gap
        for (int r = 0; r < 3; r++) begin
            k = int'($urandom_range(4, 1));
            d0 = done_seen;
            iRUN = 1'b1;
            tick();
            tick();
            for (int j = 0; j < k; j++) begin
                hi = int'($urandom_range(30, 5));
                lo = int'($urandom_range(10, 2));
                iFVAL = 1'b1;
                repeat (hi) tick();
                iFVAL = 1'b0;
                repeat (lo) tick();
            end
            iRUN = 1'b0;
            tick();
            chk("cont_stop_state", 32'(oSTATE), 3);
            tick();
            chk("cont_idle_state", 32'(oSTATE), 0);
            chk("cont_frames", 32'(oFRAME_CNT), 32'(k));
            chk("cont_no_done", 32'(done_seen - d0), 0);
        end

        // Abort on the final fall of a burst suppresses completion
        reset_all();
        d0 = done_seen;
        iNUM_FRAMES = 8'd2;
        iSNAP = 1'b1;
        tick();
        iSNAP = 1'b0;
        tick();
        iFVAL = 1'b1;
        repeat (20) tick();
        iFVAL = 1'b0;
        repeat (10) tick();
        iFVAL = 1'b1;
        repeat (20) tick();
        iFVAL = 1'b0;
        iABORT = 1'b1;
        tick();
        iABORT = 1'b0;
        chk("abort_state", 32'(oSTATE), 0);
        chk("abort_end", 32'(oEND), 1);
        chk("abort_no_done", 32'(done_seen - d0), 0);
        chk("abort_frames", 32'(oFRAME_CNT), 2);

        // Abort mid-frame in a continuous session
        iRUN = 1'b1;
        tick();
        tick();
        iFVAL = 1'b1;
        repeat (4) tick();
        iABORT = 1'b1;
        iRUN = 1'b0;
        tick();
        iABORT = 1'b0;
        chk("abort_cont_state", 32'(oSTATE), 0);
        chk("abort_cont_busy", 32'(oBUSY), 0);
        iFVAL = 1'b0;
        tick();

        // Watchdog with a 50-cycle limit and frame-valid stuck low
        reset_all();
        iRUN = 1'b1;
        repeat (51) tick();
        chk("wd_before_state", 32'(w_state), 2);
        chk("wd_before_flag", 32'(w_timeout), 0);
        tick();
        chk("wd_fault_state", 32'(w_state), 4);
        chk("wd_fault_flag", 32'(w_timeout), 1);
        chk("wd_fault_end", 32'(w_end), 1);
        chk("wd_fault_busy", 32'(w_busy), 0);
        iNUM_FRAMES = 8'd2;
        iSNAP = 1'b1;
        tick();
        iSNAP = 1'b0;
        repeat (3) tick();
        chk("wd_fault_sticky_state", 32'(w_state), 4);
        chk("wd_fault_sticky_flag", 32'(w_timeout), 1);
        iCLR = 1'b1;
        iRUN = 1'b0;
        tick();
        iCLR = 1'b0;
        chk("wd_clr_state", 32'(w_state), 0);
        chk("wd_clr_flag", 32'(w_timeout), 0);

        // Error counting with saturation and clear precedence
        reset_all();
        n = int'($urandom_range(200, 10));
        for (int i = 0; i < 300; i++) begin
            iCAP_ERR = 1'b1;
            tick();
            iCAP_ERR = 1'b0;
            repeat (int'($urandom_range(2, 0))) tick();
            if (i == n - 1) chk("err_partial", 32'(oERR_CNT), 32'(n));
        end
        chk("err_saturated", 32'(oERR_CNT), 255);
        iCLR = 1'b1;
        iCAP_ERR = 1'b1;
        tick();
        iCLR = 1'b0;
        iCAP_ERR = 1'b0;
        chk("err_clear_wins", 32'(oERR_CNT), 0);

        // Reset mid-capture beats abort and clear
        iRUN = 1'b1;
        tick();
        tick();
        iFVAL = 1'b1;
        iCAP_ERR = 1'b1;
        repeat (3) tick();
        iCAP_ERR = 1'b0;
        chk("prerst_frames", 32'(oFRAME_CNT), 1);
        chk("prerst_errs", 32'(oERR_CNT), 3);
        iRST = 1'b1;
        iABORT = 1'b1;
        iCLR = 1'b1;
        tick();
        chk_reset_vals("midrst");
        iRST = 1'b0;
        iABORT = 1'b0;
        iCLR = 1'b0;
        iRUN = 1'b0;
        iFVAL = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccd_capture_ctrl.md
CCD_CAPTURE_CTRL -- requirements
Module: ccd_capture_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 5_000_000, is the watchdog limit in iCLK cycles with no iFVAL edge (100 ms at 50 MHz).
REQ-002 Parameter NUM_W, default 8, is the width of iNUM_FRAMES.
REQ-003 The block SHALL have one clock and a synchronous active-high reset, with ports as below.
- iCLK  in  1  sole clock; all logic on its rising edge.
- iRST  in  1  synchronous, active-high reset.
- iRUN  in  1  level; continuous capture while high.
- iSNAP  in  1  one-cycle pulse; start single-shot burst.
- iNUM_FRAMES  in  NUM_W  burst length, sampled on the accepted iSNAP.
- iABORT  in  1  one-cycle pulse; stop immediately.
- iCLR  in  1  one-cycle pulse; clear fault and error count.
- iFVAL  in  1  sensor frame-valid, already synchronous to iCLK.
- iCAP_ERR  in  1  error pulse from the capture datapath.
- oEND  out  1  capture gate to the datapath; 0 = capture enabled.
- oBUSY  out  1  high in ARM, CAPTURE and STOP.
- oDONE  out  1  one-cycle pulse when a burst completes.
- oTIMEOUT  out  1  sticky watchdog fault flag.
- oFRAME_CNT  out  16  frames started in the current session.
- oERR_CNT  out  8  saturating count of iCAP_ERR pulses.
- oSTATE  out  3  current state encoding.

Function
REQ-004 States SHALL be IDLE=0, ARM=1, CAPTURE=2, STOP=3, FAULT=4; oSTATE SHALL output the state register directly.
REQ-005 FVAL edges SHALL be detected against a one-cycle-delayed copy of iFVAL: rise = 01, fall = 10.
REQ-006 IDLE: oEND=1.
- iSNAP with iNUM_FRAMES!=0 SHALL latch the target, set single mode, clear oFRAME_CNT and go to ARM.
- Otherwise iRUN=1 SHALL set continuous mode, clear oFRAME_CNT and go to ARM.
- iSNAP has priority over iRUN; iSNAP with iNUM_FRAMES=0 is ignored.
REQ-007 ARM: oEND=1; the first cycle with iFVAL=0 SHALL go to CAPTURE, so the datapath is only ever released between frames.
REQ-008 CAPTURE: oEND=0; each FVAL rise SHALL increment oFRAME_CNT (16-bit, wraps 0xFFFF->0).
REQ-009 Single mode: on the FVAL fall where oFRAME_CNT equals the target, SHALL go to IDLE and pulse oDONE for the same cycle that oEND returns to 1.
REQ-010 Continuous mode: iRUN=0 in CAPTURE SHALL go to STOP; iRUN is ignored in single mode.
REQ-011 STOP: oEND=0; SHALL go to IDLE on the first cycle with iFVAL=0 (immediately if already low), so the current frame is always finished; no oDONE.
REQ-012 Watchdog: a counter SHALL run in ARM, CAPTURE and STOP, clear on any FVAL edge or state change, and on reaching TIMEOUT_CYC-1 go to FAULT and set oTIMEOUT.
REQ-013 FAULT: oEND=1; oTIMEOUT stays set; iCLR SHALL go to IDLE and clear oTIMEOUT. iRUN and iSNAP are ignored in FAULT.
REQ-014 iABORT in ARM, CAPTURE or STOP SHALL go to IDLE next cycle with oEND=1 and no oDONE; it beats every other same-cycle event, including timeout and burst completion.
REQ-015 iCAP_ERR SHALL increment oERR_CNT, saturating at 255.
- iCLR SHALL zero oERR_CNT in any state.
- iCLR in the same cycle as iCAP_ERR leaves oERR_CNT=0.
REQ-016 Every output SHALL be registered; a state transition is visible on oEND, oBUSY and oSTATE one cycle after its cause.

Reset
REQ-017 iRST SHALL force state IDLE, oEND=1, oBUSY=0, oDONE=0, oTIMEOUT=0, oFRAME_CNT=0, oERR_CNT=0, watchdog=0, delayed FVAL=0, mode=continuous, target=0.
REQ-018 iRST mid-capture SHALL take effect on the next edge with no oDONE, and SHALL take priority over iABORT and iCLR.

Structure
REQ-019 Package ccd_ctrl_pkg SHALL hold the state encodings, the default TIMEOUT_CYC and the widths 16 (frame count) and 8 (error count).
REQ-020 Sub-module ccd_fval_edge SHALL register iFVAL and produce rise/fall pulses; all other logic SHALL be in ccd_capture_ctrl.

Verification
REQ-021 Snap burst: iSNAP with iNUM_FRAMES=3, three 100-cycle FVAL frames -> oFRAME_CNT=3, one oDONE pulse at the third fall, oEND=1 afterwards.
REQ-022 Mid-frame arm: iRUN raised while iFVAL=1 -> oEND stays 1 until iFVAL falls; the partial frame is not counted.
REQ-023 Graceful stop: iRUN dropped mid-frame -> STOP, oEND=0 until the FVAL fall, then IDLE with no oDONE.
REQ-024 Timeout: TIMEOUT_CYC=50, iRUN=1, iFVAL stuck at 0 -> FAULT and oTIMEOUT=1 after 50 cycles; iCLR -> IDLE, oTIMEOUT=0.
REQ-025 Abort precedence: iABORT in the same cycle as the final FVAL fall of a burst -> IDLE with no oDONE.
REQ-026 Error count: 300 iCAP_ERR pulses -> oERR_CNT=255; iCLR -> 0; iRST mid-CAPTURE -> all reset values on the next cycle.
